// File: rtl/pipe_trap_ctrl.sv
// ============================================================================
// pipe_trap_ctrl : pipeline stall/flush merge with trap-entry and mret sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_trap_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_exe_i,
  input  logic        stallreq_mem_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] exception_i,
  input  logic [31:0] inst_addr_i,
  input  logic        int_req_i,
  input  logic        mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        flush_int_o,
  output logic [31:0] new_pc_o,
  output logic        new_pc_valid_o,
  output logic        csr_we_o,
  output logic        csr_mret_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mcause_o
);

  localparam logic [5:0] STALL_ALL = 6'b011111;
  localparam logic [5:0] STALL_EXE = 6'b001111;
  localparam logic [5:0] STALL_ID  = 6'b000111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_TRAP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q, mcause_d;
  logic        mret_q, mret_d;
  logic        trap_cond;
  logic        int_pending;

  assign int_pending = int_req_i & mie_i & (inst_addr_i != 32'd0);
  assign trap_cond   = (state_q == S_IDLE) & ((exception_i != 32'd0) | int_pending);

  // First matching exception bit wins; interrupt is the fallback cause.
  always_comb begin
    mcause_d = 32'h8000_000B;
    mret_d   = 1'b0;
    if (exception_i[0])      mcause_d = 32'd11;
    else if (exception_i[1]) mcause_d = 32'd3;
    else if (exception_i[2]) mcause_d = 32'd2;
    else if (exception_i[3]) mcause_d = 32'd4;
    else if (exception_i[4]) mcause_d = 32'd6;
    else if (exception_i[8]) begin
      mcause_d = 32'd0;
      mret_d   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (trap_cond) state_d = stallreq_mem_i ? S_DRAIN : S_TRAP;
      S_DRAIN: if (!stallreq_mem_i) state_d = S_TRAP;
      S_TRAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mepc_q   <= 32'd0;
      mcause_q <= 32'd0;
      mret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (trap_cond) begin
        mepc_q   <= inst_addr_i;
        mcause_q <= mcause_d;
        mret_q   <= mret_d;
      end
    end
  end

  always_comb begin
    stall_o        = 6'b000000;
    flush_o        = 1'b0;
    flush_int_o    = 1'b0;
    new_pc_o       = 32'd0;
    new_pc_valid_o = 1'b0;
    csr_we_o       = 1'b0;
    csr_mret_o     = 1'b0;

    if (trap_cond || state_q == S_DRAIN) stall_o = STALL_ALL;
    else if (state_q == S_TRAP)          stall_o = 6'b000000;
    else if (stallreq_mem_i)             stall_o = STALL_ALL;
    else if (stallreq_exe_i)             stall_o = STALL_EXE;
    else if (stallreq_id_i)              stall_o = STALL_ID;

    if (state_q == S_TRAP) begin
      flush_int_o    = 1'b1;
      new_pc_valid_o = 1'b1;
      csr_we_o       = 1'b1;
      csr_mret_o     = mret_q;
      new_pc_o       = mret_q ? mepc_i : mtvec_i;
    end else if (state_q == S_IDLE && !trap_cond && !stallreq_mem_i &&
                 !stallreq_exe_i && branch_i) begin
      flush_o        = 1'b1;
      new_pc_o       = branch_target_i;
      new_pc_valid_o = 1'b1;
    end
  end

  assign mepc_o   = mepc_q;
  assign mcause_o = mcause_q;

endmodule

`default_nettype wire
